// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - register file with sticky hardware flags, atomic test-and-clear and wait-on-flag FSM
// Optional macro REGFILE_BYPASS_EN forwards port-B write data to same-cycle reads.
module param_register_file #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int FLAG_W    = 7,
  parameter int FLAG_EDGE = 0,
  parameter int BIT_W     = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] a_addr,
  output logic [DATA_W-1:0] a_data_out,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data_in,
  input  logic              b_wr_enable,
  output logic [DATA_W-1:0] b_data_out,
  input  logic [FLAG_W-1:0] flag_inputs,
  input  logic              is_atc,
  input  logic [BIT_W-1:0]  atc_bit,
  output logic              atc_out,
  input  logic              wait_req,
  input  logic [BIT_W-1:0]  wait_bit,
  output logic              wait_busy,
  output logic              wait_ack,
  output logic [DATA_W-1:0] reg_gout,
  output logic [DATA_W-1:0] reg_dout,
  output logic [DATA_W-1:0] reg_flag
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] FLAG_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DOUT_ADDR = ADDR_W'(DEPTH - 2);
  localparam logic [ADDR_W-1:0] GOUT_ADDR = ADDR_W'(DEPTH - 3);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  // FLAG lives in its own register; its array slot is never written and stays zero.
  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [FLAG_W-1:0] flag_q, flag_d, hist_q;
  logic [FLAG_W-1:0] set_vec, atc_clr, fsm_clr;
  logic [DATA_W-1:0] flag_full;
  logic [BIT_W-1:0]  wbit_q;
  state_e            state_q;
  logic              wait_busy_q, wait_ack_q;
  logic              wr_en, atc_fire, wait_hit;

  function automatic logic bit_ok(input logic [BIT_W-1:0] b);
    return {1'b0, b} < (BIT_W + 1)'(DATA_W);
  endfunction

  always_comb begin
    flag_full = '0;
    flag_full[FLAG_W-1:0] = flag_q;
  end

  assign wr_en    = enable && b_wr_enable && (b_addr != FLAG_ADDR);
  assign atc_fire = enable && is_atc && bit_ok(atc_bit);
  assign atc_out  = is_atc && bit_ok(atc_bit) && flag_full[atc_bit];

  // A same-cycle ATC on the watched bit takes the event; the FSM keeps waiting.
  assign wait_hit = (state_q == S_WAIT) && bit_ok(wbit_q) && flag_full[wbit_q]
                    && !(atc_fire && (atc_bit == wbit_q));

  // Hardware sets are OR-ed in last so they win over any clear on the same bit.
  always_comb begin
    for (int i = 0; i < FLAG_W; i++) begin
      set_vec[i] = (FLAG_EDGE != 0) ? (flag_inputs[i] & ~hist_q[i]) : flag_inputs[i];
      atc_clr[i] = atc_fire && (atc_bit == BIT_W'(i));
      fsm_clr[i] = wait_hit && (wbit_q == BIT_W'(i));
    end
    flag_d = (flag_q & ~atc_clr & ~fsm_clr) | set_vec;
  end

  always_comb begin
    a_data_out = (a_addr == FLAG_ADDR) ? flag_full : regs_q[a_addr];
    b_data_out = (b_addr == FLAG_ADDR) ? flag_full : regs_q[b_addr];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && (a_addr == b_addr)) a_data_out = b_data_in;
    if (wr_en) b_data_out = b_data_in;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      flag_q      <= '0;
      hist_q      <= '0;
      wbit_q      <= '0;
      state_q     <= S_IDLE;
      wait_busy_q <= 1'b0;
      wait_ack_q  <= 1'b0;
    end else begin
      if (wr_en) regs_q[b_addr] <= b_data_in;
      flag_q <= flag_d;
      hist_q <= flag_inputs;
      case (state_q)
        S_IDLE: begin
          if (enable && wait_req) begin
            wbit_q      <= wait_bit;
            state_q     <= S_WAIT;
            wait_busy_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (wait_hit) begin
            state_q     <= S_DONE;
            wait_busy_q <= 1'b0;
            wait_ack_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q    <= S_IDLE;
          wait_ack_q <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          wait_busy_q <= 1'b0;
          wait_ack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wait_busy = wait_busy_q;
  assign wait_ack  = wait_ack_q;
  assign reg_gout  = regs_q[GOUT_ADDR];
  assign reg_dout  = regs_q[DOUT_ADDR];
  assign reg_flag  = flag_full;

endmodule

// File: tb/tb_param_register_file.sv
// tb/tb_param_register_file.sv - scoreboard bench for param_register_file (level and edge instances)
module tb_param_register_file;

  logic       clk = 1'b0;
  logic       reset, enable, b_wr_enable, is_atc, wait_req;
  logic [4:0] a_addr, b_addr;
  logic [7:0] b_data_in;
  logic [6:0] flag_inputs;
  logic [2:0] atc_bit, wait_bit;

  logic [7:0] a_data_out, b_data_out, reg_gout, reg_dout, reg_flag;
  logic       atc_out, wait_busy, wait_ack;
  logic [7:0] e_a_data_out, e_b_data_out, e_reg_gout, e_reg_dout, e_reg_flag;
  logic       e_atc_out, e_wait_busy, e_wait_ack;

  always #5 clk = ~clk;

  param_register_file #(.DATA_W(8), .ADDR_W(5), .FLAG_W(7), .FLAG_EDGE(0)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .a_addr(a_addr), .a_data_out(a_data_out),
    .b_addr(b_addr), .b_data_in(b_data_in), .b_wr_enable(b_wr_enable), .b_data_out(b_data_out),
    .flag_inputs(flag_inputs), .is_atc(is_atc), .atc_bit(atc_bit), .atc_out(atc_out),
    .wait_req(wait_req), .wait_bit(wait_bit), .wait_busy(wait_busy), .wait_ack(wait_ack),
    .reg_gout(reg_gout), .reg_dout(reg_dout), .reg_flag(reg_flag)
  );

  param_register_file #(.DATA_W(8), .ADDR_W(5), .FLAG_W(7), .FLAG_EDGE(1)) dut_e (
    .clk(clk), .reset(reset), .enable(enable),
    .a_addr(a_addr), .a_data_out(e_a_data_out),
    .b_addr(b_addr), .b_data_in(b_data_in), .b_wr_enable(b_wr_enable), .b_data_out(e_b_data_out),
    .flag_inputs(flag_inputs), .is_atc(is_atc), .atc_bit(atc_bit), .atc_out(e_atc_out),
    .wait_req(wait_req), .wait_bit(wait_bit), .wait_busy(e_wait_busy), .wait_ack(e_wait_ack),
    .reg_gout(e_reg_gout), .reg_dout(e_reg_dout), .reg_flag(e_reg_flag)
  );

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ob[$];
  int         total = 0;
  int         bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input string n, input logic [7:0] v);
    sb.push_back('{n, v});
  endtask

  task automatic test_reset();
    exp_t e; logic [7:0] o;
    reset = 1'b1; enable = 1'b0; b_wr_enable = 1'b0; is_atc = 1'b0; wait_req = 1'b0;
    a_addr = '0; b_addr = '0; b_data_in = '0; flag_inputs = '0; atc_bit = '0; wait_bit = '0;
    tick(); tick();
    want("rst_gout", 8'h00); ob.push_back(reg_gout);
    want("rst_dout", 8'h00); ob.push_back(reg_dout);
    want("rst_flag", 8'h00); ob.push_back(reg_flag);
    want("rst_busy", 8'h00); ob.push_back({7'b0, wait_busy});
    want("rst_ack", 8'h00);  ob.push_back({7'b0, wait_ack});
    want("rst_adata", 8'h00); ob.push_back(a_data_out);
    want("rst_e_flag", 8'h00); ob.push_back(e_reg_flag);
    reset = 1'b0;
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = ob.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_write();
    exp_t e; logic [7:0] o;
    enable = 1'b1; b_wr_enable = 1'b1; b_addr = 5'd29; b_data_in = 8'hA5;
    want("wr_gout", 8'hA5);
    tick(); ob.push_back(reg_gout);
    b_addr = 5'd31; b_data_in = 8'hFF;
    want("wr_flag_dropped", 8'h00);
    want("wr_gout_kept", 8'hA5);
    tick(); ob.push_back(reg_flag); ob.push_back(reg_gout);
    b_addr = 5'd30; b_data_in = 8'h5A;
    want("wr_dout", 8'h5A);
    tick(); ob.push_back(reg_dout);
    b_wr_enable = 1'b0; a_addr = 5'd29; b_addr = 5'd30;
    want("rd_a_gout", 8'hA5); want("rd_b_dout", 8'h5A);
    #1; ob.push_back(a_data_out); ob.push_back(b_data_out);
    a_addr = 5'd31;
    want("rd_a_flag", 8'h00);
    #1; ob.push_back(a_data_out);
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = ob.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_atc();
    exp_t e; logic [7:0] o;
    flag_inputs = 7'h08;
    want("atc_flag_set", 8'h08);
    tick(); ob.push_back(reg_flag);
    is_atc = 1'b1; atc_bit = 3'd3;
    want("atc_out_collide", 8'h01);
    #1; ob.push_back({7'b0, atc_out});
    want("atc_flag_kept", 8'h08);
    tick(); ob.push_back(reg_flag);
    flag_inputs = 7'h00;
    want("atc_out_repeat", 8'h01);
    #1; ob.push_back({7'b0, atc_out});
    want("atc_flag_cleared", 8'h00);
    tick(); ob.push_back(reg_flag);
    is_atc = 1'b0;
    want("atc_out_idle", 8'h00);
    #1; ob.push_back({7'b0, atc_out});
    flag_inputs = 7'h02;
    tick();
    flag_inputs = 7'h00; enable = 1'b0; is_atc = 1'b1; atc_bit = 3'd1;
    want("atc_out_disabled", 8'h01);
    #1; ob.push_back({7'b0, atc_out});
    want("atc_no_clear_disabled", 8'h02);
    tick(); ob.push_back(reg_flag);
    enable = 1'b1;
    want("atc_clear_enabled", 8'h00);
    tick(); ob.push_back(reg_flag);
    is_atc = 1'b0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = ob.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_wait();
    exp_t e; logic [7:0] o;
    int n;
    wait_bit = 3'd2; wait_req = 1'b1;
    want("wt_busy_accept", 8'h01); want("wt_ack_accept", 8'h00);
    tick(); ob.push_back({7'b0, wait_busy}); ob.push_back({7'b0, wait_ack});
    wait_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      want("wt_busy_hold", 8'h01);
      tick(); ob.push_back({7'b0, wait_busy});
    end
    flag_inputs = 7'h04;
    want("wt_busy_at_pulse", 8'h01); want("wt_flag_pulse", 8'h04);
    tick(); ob.push_back({7'b0, wait_busy}); ob.push_back(reg_flag);
    flag_inputs = 7'h00;
    want("wt_ack_latency", 8'd1);
    n = 0;
    while (!wait_ack && n < 8) begin tick(); n++; end
    ob.push_back(8'(n));
    want("wt_ack", 8'h01); want("wt_busy_done", 8'h00); want("wt_flag_cleared", 8'h00);
    ob.push_back({7'b0, wait_ack}); ob.push_back({7'b0, wait_busy}); ob.push_back(reg_flag);
    want("wt_ack_one_cycle", 8'h00);
    tick(); ob.push_back({7'b0, wait_ack});

    flag_inputs = 7'h20;
    tick();
    wait_bit = 3'd5; wait_req = 1'b1;
    want("ws_busy", 8'h01); want("ws_ack_early", 8'h00);
    tick(); ob.push_back({7'b0, wait_busy}); ob.push_back({7'b0, wait_ack});
    wait_req = 1'b0;
    want("ws_ack_min_latency", 8'h01); want("ws_set_beats_fsm", 8'h20);
    tick(); ob.push_back({7'b0, wait_ack}); ob.push_back(reg_flag);
    flag_inputs = 7'h00; is_atc = 1'b1; atc_bit = 3'd5;
    want("ws_flag_clear", 8'h00); want("ws_ack_drop", 8'h00);
    tick(); ob.push_back(reg_flag); ob.push_back({7'b0, wait_ack});
    is_atc = 1'b0;

    wait_bit = 3'd6; wait_req = 1'b1;
    tick();
    wait_req = 1'b0; flag_inputs = 7'h40;
    want("wc_flag", 8'h40); want("wc_busy", 8'h01);
    tick(); ob.push_back(reg_flag); ob.push_back({7'b0, wait_busy});
    flag_inputs = 7'h00; is_atc = 1'b1; atc_bit = 3'd6;
    want("wc_atc_out", 8'h01);
    #1; ob.push_back({7'b0, atc_out});
    want("wc_atc_wins_flag", 8'h00); want("wc_still_busy", 8'h01); want("wc_no_ack", 8'h00);
    tick(); ob.push_back(reg_flag); ob.push_back({7'b0, wait_busy}); ob.push_back({7'b0, wait_ack});
    is_atc = 1'b0;
    want("wc_stuck_busy", 8'h01);
    tick(); ob.push_back({7'b0, wait_busy});

    flag_inputs = 7'h42;
    want("wd_flag", 8'h42);
    tick(); ob.push_back(reg_flag);
    flag_inputs = 7'h00; is_atc = 1'b1; atc_bit = 3'd1;
    want("wd_both_clear", 8'h00); want("wd_ack", 8'h01);
    tick(); ob.push_back(reg_flag); ob.push_back({7'b0, wait_ack});
    is_atc = 1'b0;
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = ob.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_reset_midwait();
    exp_t e; logic [7:0] o;
    wait_bit = 3'd4; wait_req = 1'b1;
    tick();
    wait_req = 1'b0; flag_inputs = 7'h01;
    tick();
    flag_inputs = 7'h00;
    want("rm_pre_busy", 8'h01); want("rm_pre_flag", 8'h01);
    want("rm_pre_gout", 8'hA5); want("rm_pre_dout", 8'h5A);
    ob.push_back({7'b0, wait_busy}); ob.push_back(reg_flag); ob.push_back(reg_gout); ob.push_back(reg_dout);
    reset = 1'b1;
    tick();
    a_addr = 5'd29;
    #1;
    want("rm_gout", 8'h00); want("rm_dout", 8'h00); want("rm_flag", 8'h00);
    want("rm_busy", 8'h00); want("rm_ack", 8'h00); want("rm_adata", 8'h00);
    ob.push_back(reg_gout); ob.push_back(reg_dout); ob.push_back(reg_flag);
    ob.push_back({7'b0, wait_busy}); ob.push_back({7'b0, wait_ack}); ob.push_back(a_data_out);
    reset = 1'b0;
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = ob.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_edge();
    exp_t e; logic [7:0] o;
    reset = 1'b1; flag_inputs = 7'h01;
    want("ed_in_reset", 8'h00);
    tick(); ob.push_back(e_reg_flag);
    reset = 1'b0;
    want("ed_held_counts", 8'h01); want("lv_set", 8'h01);
    tick(); ob.push_back(e_reg_flag); ob.push_back(reg_flag);
    is_atc = 1'b1; atc_bit = 3'd0;
    want("ed_atc_out", 8'h01);
    #1; ob.push_back({7'b0, e_atc_out});
    want("ed_cleared", 8'h00); want("lv_set_beats_atc", 8'h01);
    tick(); ob.push_back(e_reg_flag); ob.push_back(reg_flag);
    is_atc = 1'b0;
    want("ed_no_reset_c", 8'h00);
    tick(); ob.push_back(e_reg_flag);
    want("ed_no_reset_d", 8'h00);
    tick(); ob.push_back(e_reg_flag);
    flag_inputs = 7'h00;
    want("ed_low", 8'h00);
    tick(); ob.push_back(e_reg_flag);
    flag_inputs = 7'h01;
    want("ed_new_rise", 8'h01);
    tick(); ob.push_back(e_reg_flag);
    flag_inputs = 7'h00; is_atc = 1'b1; atc_bit = 3'd0;
    want("ed_cleanup", 8'h00); want("lv_cleanup", 8'h00);
    tick(); ob.push_back(e_reg_flag); ob.push_back(reg_flag);
    is_atc = 1'b0;
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = ob.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [7:0] o;
    logic [7:0] model [29];
    logic [4:0] ad;
    for (int i = 0; i < 29; i++) model[i] = 8'h00;
    b_wr_enable = 1'b1;
    for (int i = 0; i < 12; i++) begin
      ad = 5'($urandom_range(0, 28));
      b_addr = ad; b_data_in = 8'($urandom);
      model[ad] = b_data_in;
      tick();
    end
    b_wr_enable = 1'b0;
    for (int i = 0; i < 29; i++) begin
      a_addr = 5'(i); b_addr = 5'(28 - i);
      want("b2b_a", model[i]); want("b2b_b", model[28 - i]);
      #1; ob.push_back(a_data_out); ob.push_back(b_data_out);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = ob.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  task automatic test_bypass();
    exp_t e; logic [7:0] o;
    logic [7:0] old_v, new_v, hit_v;
    old_v = 8'h11; new_v = 8'h3C;
`ifdef REGFILE_BYPASS_EN
    hit_v = new_v;
`else
    hit_v = old_v;
`endif
    b_wr_enable = 1'b1; b_addr = 5'd5; b_data_in = 8'h77;
    tick();
    b_addr = 5'd4; b_data_in = old_v;
    tick();
    b_data_in = new_v; a_addr = 5'd4;
    want("byp_a_same_cycle", hit_v); want("byp_b_same_cycle", hit_v);
    #1; ob.push_back(a_data_out); ob.push_back(b_data_out);
    a_addr = 5'd5;
    want("byp_a_other_addr", 8'h77);
    #1; ob.push_back(a_data_out);
    tick();
    b_wr_enable = 1'b0; a_addr = 5'd4;
    want("byp_after_write", new_v);
    #1; ob.push_back(a_data_out);
    b_wr_enable = 1'b1; b_addr = 5'd31; b_data_in = 8'hFF; a_addr = 5'd31;
    want("byp_a_flag_never", 8'h00); want("byp_b_flag_never", 8'h00);
    #1; ob.push_back(a_data_out); ob.push_back(b_data_out);
    tick();
    b_wr_enable = 1'b0;
    want("byp_flag_unchanged", 8'h00);
    ob.push_back(reg_flag);
    while (sb.size() != 0) begin
      e = sb.pop_front(); o = ob.pop_front(); total++;
      if (o !== e.val) begin bad++; $display("FAIL %s: got %h want %h", e.name, o, e.val); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_atc();
    test_wait();
    test_reset_midwait();
    test_edge();
    test_back_to_back();
    test_bypass();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/param_register_file.md
# param_register_file

Parametrised CPU register file: two combinational read ports, one read/write port, and a sticky hardware flag register with atomic test-and-clear. Adds a wait-on-flag handshake FSM so the control unit can stall until a flag event arrives, plus selectable level or rising-edge flag capture. It sits between the decoder/ALU datapath and the I/O blocks, and exports the GOUT, DOUT and FLAG special registers.

## Interface
- DATA_W, 8: register width; must be ≥ FLAG_W and ≥ 2.
- ADDR_W, 5: address width; depth = 2^ADDR_W.
- FLAG_W, 7: number of hardware flag bits, stored in FLAG[FLAG_W-1:0].
- FLAG_EDGE, 0: flag capture mode; 0 = level capture, 1 = rising-edge capture.
- Special register addresses (fixed): FLAG = 2^ADDR_W-1, DOUT = 2^ADDR_W-2, GOUT = 2^ADDR_W-3.
- BIT_W = $clog2(DATA_W), derived.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  CPU advance; gates port-b writes, ATC and wait acceptance.
- a_addr  in  ADDR_W  read port A address.
- a_data_out  out  DATA_W  read port A data.
- b_addr  in  ADDR_W  port B address.
- b_data_in  in  DATA_W  port B write data.
- b_wr_enable  in  1  port B write strobe.
- b_data_out  out  DATA_W  port B read data.
- flag_inputs  in  FLAG_W  hardware flag event sources.
- is_atc  in  1  atomic test-and-clear request.
- atc_bit  in  BIT_W  FLAG bit to test.
- atc_out  out  1  tested bit value.
- wait_req  in  1  request to wait on a flag bit.
- wait_bit  in  BIT_W  FLAG bit to wait on.
- wait_busy  out  1  FSM is in the WAIT state.
- wait_ack  out  1  one-cycle completion pulse.
- reg_gout, reg_dout, reg_flag  out  DATA_W each  GOUT, DOUT and FLAG contents.

## Operation
- **Reset.** All registers = 0, edge history = 0, FSM = IDLE. Every output is 0 except the combinational reads, which read the zeroed array.
- **Reads.** a_data_out and b_data_out are combinational from the array. atc_out = is_atc ? FLAG[atc_bit] : 0.
- **Port B write.** Occurs when enable && b_wr_enable && b_addr != FLAG. A write to FLAG is silently dropped.
- **Flag set condition for bit i < FLAG_W.**
  - Level mode: flag_inputs[i] is high.
  - Edge mode: flag_inputs[i] && !hist[i]. hist <= flag_inputs every cycle, regardless of enable.
  - Sets happen regardless of enable. FLAG bits at index ≥ FLAG_W always read 0.
- **ATC.** When enable && is_atc, the edge clears FLAG[atc_bit]. If atc_bit ≥ DATA_W, nothing happens.
- **Wait FSM.**
  - IDLE: on enable && wait_req, latch wait_bit and go to WAIT.
  - WAIT: if FLAG[latched bit] == 1 and no same-cycle ATC on the same bit, clear that bit and go to DONE. Otherwise stay in WAIT. WAIT and DONE advance regardless of enable.
  - DONE: wait_ack = 1 for exactly one cycle, then return to IDLE. wait_req is ignored outside IDLE.
- **Priority when events coincide on one FLAG bit, in one cycle.**
  - A hardware set beats an ATC clear or FSM clear. The bit stays 1; the ATC still returns 1; the FSM still completes.
  - An ATC takes the event over the FSM. The FSM stays in WAIT.
  - An ATC and an FSM clear on different bits both apply.
- **Reset mid-wait.** Reset forces IDLE with wait_ack = 0 on the next edge; the pending wait is lost.

## Timing
- Reads have zero latency. Without bypass, a written value is visible on the cycle after the write edge.
- Flag event to reg_flag takes 1 edge. In edge mode, an input held high since before reset release counts as one edge.
- Wait on an already-set bit: req accepted at edge 1, DONE entered at edge 2, ack high in the cycle after edge 2. The minimum request-to-ack latency is 2 cycles.
- Wait on a clear bit: ack is high in the cycle after the first edge at which the bit is seen set while in WAIT.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Read ports bypass the array when enable && b_wr_enable && the write address matches the read address && the write address != FLAG.
  - On a bypass hit, a_data_out returns b_data_in in the same cycle, and b_data_out returns b_data_in whenever the bypass condition holds.
- REGFILE_BYPASS_EN undefined: reads always return stored array contents.

## Test plan
- Reset mid-wait:
  - Stimulus: reset asserted while the FSM is in WAIT, with all registers non-zero.
  - Required: next cycle, every register = 0, wait_busy = 0, wait_ack = 0.
- Write and special registers:
  - Stimulus: write 0xA5 to address 29, then 0xFF to address 31.
  - Required: reg_gout = 0xA5 the next cycle; reg_flag stays 0x00.
- ATC collision:
  - Stimulus: flag_inputs[3] pulsed high, giving FLAG = 0x08; then is_atc with atc_bit = 3, with flag_inputs[3] high again in the same cycle.
  - Required: atc_out = 1 and FLAG stays 0x08. Repeat the ATC without the input: atc_out = 1, then FLAG = 0x00.
- Wait handshake:
  - Stimulus: wait_req on bit 2 with FLAG = 0; flag_inputs[2] pulsed 5 cycles later.
  - Required: wait_busy stays high until the bit is seen; then one cycle of wait_ack, and FLAG[2] = 0.
- Edge mode (FLAG_EDGE = 1):
  - Stimulus: hold flag_inputs[0] high for 4 cycles; clear FLAG[0] by ATC in cycle 2.
  - Required: the bit is not re-set until the input drops and rises again.
- Bypass (with REGFILE_BYPASS_EN):
  - Stimulus: write 0x3C to address 4 with a_addr = 4.
  - Required: a_data_out = 0x3C in the same cycle. Without the macro, the old value is returned in that cycle.
